// File: rtl/uart_tx_arbiter.sv
// Shares one byte-wide UART transmitter between two message sources.
// Grants whole messages, alternates priority round-robin, and inserts an idle gap between messages.
module uart_tx_arbiter #(
  parameter int DATA_W     = 8,
  parameter int GAP_CYCLES = 16,
  parameter int MAX_LEN    = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] s0_data,
  input  logic              s0_valid,
  input  logic              s0_last,
  output logic              s0_ready,
  input  logic [DATA_W-1:0] s1_data,
  input  logic              s1_valid,
  input  logic              s1_last,
  output logic              s1_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [1:0]        grant,
  output logic              busy,
  output logic              trunc
);

  localparam int CNT_W    = $clog2(MAX_LEN + 1);
  localparam int GAP_W    = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam int GAP_LAST = (GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  state_t            state_r, state_s;
  logic [1:0]        grant_r, grant_s;
  logic [CNT_W-1:0]  byte_cnt_r, byte_cnt_s;
  logic [GAP_W-1:0]  gap_cnt_r, gap_cnt_s;
  logic              rr_ptr_r, rr_ptr_s;  // 1: s1 has priority on the next tie
  logic              trunc_r, trunc_s;
  logic              own_valid_s;
  logic              own_last_s;
  logic              xfer_s;

  // Owner datapath: route the granted source straight to the serializer
  always_comb begin
    own_valid_s = 1'b0;
    own_last_s  = 1'b0;
    m_data      = '0;
    s0_ready    = 1'b0;
    s1_ready    = 1'b0;
    if ((state_r == ST_GRANT) && (grant_r == 2'b01)) begin
      own_valid_s = s0_valid;
      own_last_s  = s0_last;
      m_data      = s0_data;
      s0_ready    = m_ready;
    end else if ((state_r == ST_GRANT) && (grant_r == 2'b10)) begin
      own_valid_s = s1_valid;
      own_last_s  = s1_last;
      m_data      = s1_data;
      s1_ready    = m_ready;
    end else begin
      own_valid_s = 1'b0;
    end
    m_valid = own_valid_s;
    xfer_s  = own_valid_s & m_ready;
  end

  // Next-state logic: arbitration, message tracking and gap timing
  always_comb begin
    state_s    = state_r;
    grant_s    = grant_r;
    byte_cnt_s = byte_cnt_r;
    gap_cnt_s  = gap_cnt_r;
    rr_ptr_s   = rr_ptr_r;
    trunc_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (s0_valid || s1_valid) begin
          state_s    = ST_GRANT;
          byte_cnt_s = '0;
          if (s0_valid && (!s1_valid || !rr_ptr_r)) begin
            grant_s = 2'b01;
          end else begin
            grant_s = 2'b10;
          end
        end else begin
          grant_s = 2'b00;
        end
      end
      ST_GRANT: begin
        if (xfer_s) begin
          byte_cnt_s = byte_cnt_r + CNT_W'(1);
          // A last byte landing exactly on MAX_LEN is a normal end, not a truncation
          if (own_last_s || (byte_cnt_r == CNT_W'(MAX_LEN - 1))) begin
            trunc_s   = ~own_last_s;
            grant_s   = 2'b00;
            rr_ptr_s  = (grant_r == 2'b01);
            gap_cnt_s = '0;
            state_s   = (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;
          end else begin
            state_s = ST_GRANT;
          end
        end else begin
          state_s = ST_GRANT;
        end
      end
      ST_GAP: begin
        if (gap_cnt_r == GAP_W'(GAP_LAST)) begin
          state_s = ST_IDLE;
        end else begin
          gap_cnt_s = gap_cnt_r + GAP_W'(1);
        end
      end
      default: begin
        state_s = ST_IDLE;
        grant_s = 2'b00;
      end
    endcase
  end

  // State and counter registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      grant_r    <= 2'b00;
      byte_cnt_r <= '0;
      gap_cnt_r  <= '0;
      rr_ptr_r   <= 1'b0;
      trunc_r    <= 1'b0;
    end else begin
      state_r    <= state_s;
      grant_r    <= grant_s;
      byte_cnt_r <= byte_cnt_s;
      gap_cnt_r  <= gap_cnt_s;
      rr_ptr_r   <= rr_ptr_s;
      trunc_r    <= trunc_s;
    end
  end

  assign grant = grant_r;
  assign busy  = (state_r != ST_IDLE);
  assign trunc = trunc_r;

endmodule
